// File: rtl/nn_layer_seq.sv
// -----------------------------------------------------------------------------
// nn_layer_seq
// Sequential fully-connected layer: M neurons accumulate in parallel while one
// shared input element is consumed per enabled cycle. The result of each
// neuron goes through a linear or clamped-ReLU activation with gain, and the
// layer then reports the argmax of the activated outputs. A start/busy/done
// handshake lets a controller chain or poll layers.
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   en       clock enable; low freezes every register
//   start    compute request, sampled only while idle
//   Scurr    input vector, element j at [j*SIZE +: SIZE]
//   W        weights, neuron i element j at [(i*N+j)*SIZE +: SIZE]
//   b        bias, neuron i at [i*SIZE +: SIZE]
//   busy     high whenever the FSM is not idle
//   done     one-cycle completion pulse
//   Snext    activated outputs, neuron i at [i*SIZE +: SIZE]
//   max_val  largest activated output
//   max_idx  index of max_val (lowest index on ties)
//   result   one-hot of max_idx
// -----------------------------------------------------------------------------
module nn_layer_seq #(
  parameter int SIZE     = 32,
  parameter int N        = 3,
  parameter int M        = 4,
  parameter int K        = 1,
  parameter int CLIP     = 7,
  parameter int ACT_MODE = 1,
  parameter int IDXW     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  start,
  input  logic [SIZE*N-1:0]     Scurr,
  input  logic [SIZE*N*M-1:0]   W,
  input  logic [SIZE*M-1:0]     b,
  output logic                  busy,
  output logic                  done,
  output logic [SIZE*M-1:0]     Snext,
  output logic [SIZE-1:0]       max_val,
  output logic [IDXW-1:0]       max_idx,
  output logic [M-1:0]          result
);

  localparam int JW = (N > 1) ? $clog2(N) : 1;
  localparam logic [JW-1:0]          J_LAST  = JW'(N - 1);
  localparam logic [JW-1:0]          J_ONE   = JW'(1);
  localparam logic [IDXW-1:0]        K_LAST  = IDXW'(M - 1);
  localparam logic [IDXW-1:0]        K_ONE   = IDXW'(1);
  localparam logic [M-1:0]           ONEHOT0 = M'(1);
  localparam logic signed [SIZE-1:0] GAIN    = SIZE'(K);
  localparam logic signed [SIZE-1:0] CLIP_V  = SIZE'(CLIP);
  localparam logic signed [SIZE-1:0] ZERO_V  = '0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ACC  = 3'd1,
    S_ACT  = 3'd2,
    S_ARG  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                  r_state;
  logic [JW-1:0]           r_j;
  logic [IDXW-1:0]         r_k;
  logic signed [SIZE-1:0]  r_s     [N];
  logic signed [SIZE-1:0]  r_w     [M][N];
  logic signed [SIZE-1:0]  r_acc   [M];
  logic signed [SIZE-1:0]  r_snext [M];
  logic signed [SIZE-1:0]  r_run_max;
  logic [IDXW-1:0]         r_run_idx;
  logic                    r_busy;
  logic                    r_done;
  logic [SIZE-1:0]         r_max_val;
  logic [IDXW-1:0]         r_max_idx;
  logic [M-1:0]            r_result;

  logic signed [SIZE-1:0]  w_prod [M];
  logic signed [SIZE-1:0]  w_act  [M];

  // Activation: gain first (truncated to SIZE), then optional clamp. The
  // zero test looks at the raw accumulator, the clip test at the gained value.
  function automatic logic signed [SIZE-1:0] act_f(input logic signed [SIZE-1:0] a);
    logic signed [SIZE-1:0] v;
    v = a * GAIN;
    if (ACT_MODE == 0) begin
      act_f = v;
    end else if (a <= ZERO_V) begin
      act_f = ZERO_V;
    end else if (v >= CLIP_V) begin
      act_f = CLIP_V;
    end else begin
      act_f = v;
    end
  endfunction

  // Per-neuron product for the current input element and activated accumulator.
  always_comb begin
    for (int i = 0; i < M; i++) begin
      w_prod[i] = r_w[i][r_j] * r_s[r_j];
      w_act[i]  = act_f(r_acc[i]);
    end
  end

  // Main FSM: operand capture, MAC, activation, argmax scan and result latch.
  // The activation edge also seeds the running max with neuron 0, so the scan
  // only visits neurons 1..M-1 and a whole operation takes N+M+2 edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_j       <= '0;
      r_k       <= '0;
      r_run_max <= '0;
      r_run_idx <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_max_val <= '0;
      r_max_idx <= '0;
      r_result  <= '0;
      for (int j = 0; j < N; j++) begin
        r_s[j] <= '0;
      end
      for (int i = 0; i < M; i++) begin
        r_acc[i]   <= '0;
        r_snext[i] <= '0;
        for (int j = 0; j < N; j++) begin
          r_w[i][j] <= '0;
        end
      end
    end else if (en) begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            for (int j = 0; j < N; j++) begin
              r_s[j] <= Scurr[j*SIZE +: SIZE];
            end
            for (int i = 0; i < M; i++) begin
              r_acc[i] <= b[i*SIZE +: SIZE];
              for (int j = 0; j < N; j++) begin
                r_w[i][j] <= W[(i*N+j)*SIZE +: SIZE];
              end
            end
            r_j     <= '0;
            r_busy  <= 1'b1;
            r_state <= S_ACC;
          end
        end
        S_ACC: begin
          for (int i = 0; i < M; i++) begin
            r_acc[i] <= r_acc[i] + w_prod[i];
          end
          if (r_j == J_LAST) begin
            r_j     <= '0;
            r_state <= S_ACT;
          end else begin
            r_j <= r_j + J_ONE;
          end
        end
        S_ACT: begin
          for (int i = 0; i < M; i++) begin
            r_snext[i] <= w_act[i];
          end
          r_run_max <= w_act[0];
          r_run_idx <= '0;
          r_k       <= K_ONE;
          r_state   <= S_ARG;
        end
        S_ARG: begin
          // Strict compare keeps the lowest index on ties.
          if (r_snext[r_k] > r_run_max) begin
            r_run_max <= r_snext[r_k];
            r_run_idx <= r_k;
          end
          if (r_k == K_LAST) begin
            r_state <= S_DONE;
          end else begin
            r_k <= r_k + K_ONE;
          end
        end
        S_DONE: begin
          r_max_val <= r_run_max;
          r_max_idx <= r_run_idx;
          r_result  <= ONEHOT0 << r_run_idx;
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < M; gi++) begin : g_snext
      assign Snext[gi*SIZE +: SIZE] = r_snext[gi];
    end
  endgenerate

  assign busy    = r_busy;
  assign done    = r_done;
  assign max_val = r_max_val;
  assign max_idx = r_max_idx;
  assign result  = r_result;

endmodule

// File: tb/tb_nn_layer_seq.sv
module tb_nn_layer_seq;

  localparam int SIZE = 32;
  localparam int N    = 3;
  localparam int M    = 4;
  localparam int IDXW = 2;
  localparam int LAT  = N + M + 2;

  logic clk;
  logic rst_n;
  logic en;
  logic start;
  logic [SIZE*N-1:0]   Scurr_v;
  logic [SIZE*N*M-1:0] W_v;
  logic [SIZE*M-1:0]   b_v;

  logic busy_d, done_d, busy_k, done_k, busy_l, done_l;
  logic [SIZE*M-1:0] sn_d, sn_k, sn_l;
  logic [SIZE-1:0]   mv_d, mv_k, mv_l;
  logic [IDXW-1:0]   mi_d, mi_k, mi_l;
  logic [M-1:0]      rs_d, rs_k, rs_l;

  // Default configuration: clamped ReLU, K = 1, CLIP = 7.
  nn_layer_seq #(.SIZE(SIZE), .N(N), .M(M), .K(1), .CLIP(7), .ACT_MODE(1), .IDXW(IDXW)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .Scurr(Scurr_v), .W(W_v), .b(b_v),
    .busy(busy_d), .done(done_d), .Snext(sn_d), .max_val(mv_d), .max_idx(mi_d), .result(rs_d));

  // Gain 2, clamped.
  nn_layer_seq #(.SIZE(SIZE), .N(N), .M(M), .K(2), .CLIP(7), .ACT_MODE(1), .IDXW(IDXW)) u_dut_k2 (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .Scurr(Scurr_v), .W(W_v), .b(b_v),
    .busy(busy_k), .done(done_k), .Snext(sn_k), .max_val(mv_k), .max_idx(mi_k), .result(rs_k));

  // Linear activation, K = 1.
  nn_layer_seq #(.SIZE(SIZE), .N(N), .M(M), .K(1), .CLIP(7), .ACT_MODE(0), .IDXW(IDXW)) u_dut_lin (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .Scurr(Scurr_v), .W(W_v), .b(b_v),
    .busy(busy_l), .done(done_l), .Snext(sn_l), .max_val(mv_l), .max_idx(mi_l), .result(rs_l));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int s [N];
    int w [M][N];
    int b [M];
    int e_def [M];
    int i_def;
    int e_k2 [M];
    int i_k2;
    int e_lin [M];
    int i_lin;
  } vec_t;

  vec_t tbl [3];

  int cur_s [N];
  int cur_w [M][N];
  int cur_b [M];
  int ex_def [M];
  int ex_k2 [M];
  int ex_lin [M];
  int ix_def, ix_k2, ix_lin;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference activation, straight from the rules with 32-bit int arithmetic.
  function automatic int act_ref(input int acc, input int k, input int mode);
    int v;
    v = acc * k;
    if (mode == 0) return v;
    if (acc <= 0) return 0;
    if (v >= 7) return 7;
    return v;
  endfunction

  function automatic int argmax_ref(input int v [M]);
    int best;
    best = 0;
    for (int i = 1; i < M; i++) begin
      if (v[i] > v[best]) best = i;
    end
    return best;
  endfunction

  task automatic model();
    int acc;
    for (int i = 0; i < M; i++) begin
      acc = cur_b[i];
      for (int j = 0; j < N; j++) acc += cur_w[i][j] * cur_s[j];
      ex_def[i] = act_ref(acc, 1, 1);
      ex_k2[i]  = act_ref(acc, 2, 1);
      ex_lin[i] = act_ref(acc, 1, 0);
    end
    ix_def = argmax_ref(ex_def);
    ix_k2  = argmax_ref(ex_k2);
    ix_lin = argmax_ref(ex_lin);
  endtask

  task automatic load_tbl(input int e);
    cur_s  = tbl[e].s;
    cur_w  = tbl[e].w;
    cur_b  = tbl[e].b;
    ex_def = tbl[e].e_def;
    ex_k2  = tbl[e].e_k2;
    ex_lin = tbl[e].e_lin;
    ix_def = tbl[e].i_def;
    ix_k2  = tbl[e].i_k2;
    ix_lin = tbl[e].i_lin;
  endtask

  task automatic apply();
    for (int j = 0; j < N; j++) Scurr_v[j*SIZE +: SIZE] = cur_s[j];
    for (int i = 0; i < M; i++) begin
      b_v[i*SIZE +: SIZE] = cur_b[i];
      for (int j = 0; j < N; j++) W_v[(i*N+j)*SIZE +: SIZE] = cur_w[i][j];
    end
  endtask

  task automatic scramble();
    for (int j = 0; j < N; j++) Scurr_v[j*SIZE +: SIZE] = $urandom;
    for (int i = 0; i < M; i++) b_v[i*SIZE +: SIZE] = $urandom;
    for (int i = 0; i < M*N; i++) W_v[i*SIZE +: SIZE] = $urandom;
  endtask

  function automatic int rnd_val();
    if ($urandom_range(0, 7) == 0) return int'($urandom);
    return int'($urandom_range(0, 20)) - 10;
  endfunction

  task automatic chk_dut(input string tag, input logic [SIZE*M-1:0] sn, input logic [SIZE-1:0] mv,
                         input logic [IDXW-1:0] mi, input logic [M-1:0] rs, input int e [M], input int ei);
    for (int i = 0; i < M; i++) begin
      check($sformatf("%s_snext%0d", tag, i), longint'($signed(sn[i*SIZE +: SIZE])), longint'(e[i]));
    end
    check({tag, "_max_val"}, longint'($signed(mv)), longint'(e[ei]));
    check({tag, "_max_idx"}, longint'(mi), longint'(ei));
    check({tag, "_result"}, longint'(rs), longint'(1 << ei));
  endtask

  task automatic compare_all(input string tag);
    chk_dut({tag, "_def"}, sn_d, mv_d, mi_d, rs_d, ex_def, ix_def);
    chk_dut({tag, "_k2"},  sn_k, mv_k, mi_k, rs_k, ex_k2,  ix_k2);
    chk_dut({tag, "_lin"}, sn_l, mv_l, mi_l, rs_l, ex_lin, ix_lin);
  endtask

  // Count enabled-or-not edges until done rises, bounded by budget.
  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (!done_d && n < budget) begin
      step();
      n++;
    end
  endtask

  // Precondition: inputs applied and start = 1, just after an edge.
  // Returns in the cycle where done is high.
  task automatic run_op(input string tag);
    int n;
    step();
    start = 1'b0;
    scramble();
    check({tag, "_busy_rise"}, longint'(busy_d), 1);
    wait_done(60, n);
    check({tag, "_latency"}, longint'(n + 1), longint'(LAT));
    check({tag, "_done_all"}, longint'({done_d, done_k, done_l}), 7);
    check({tag, "_busy_fall"}, longint'(busy_d), 0);
    compare_all(tag);
  endtask

  initial begin
    int n;
    int e;
    int cnt;

    for (int v = 0; v < 3; v++) begin
      tbl[v].s = '{1, 1, -1};
      tbl[v].w = '{'{1, -1, 1}, '{1, 1, -1}, '{-1, -1, 1}, '{1, -1, -1}};
    end
    tbl[0].b = '{3, 3, 3, 3};
    tbl[0].e_def = '{2, 6, 0, 4};     tbl[0].i_def = 1;
    tbl[0].e_k2  = '{4, 7, 0, 7};     tbl[0].i_k2  = 1;
    tbl[0].e_lin = '{2, 6, 0, 4};     tbl[0].i_lin = 1;
    tbl[1].b = '{-10, -10, -10, -10};
    tbl[1].e_def = '{0, 0, 0, 0};     tbl[1].i_def = 0;
    tbl[1].e_k2  = '{0, 0, 0, 0};     tbl[1].i_k2  = 0;
    tbl[1].e_lin = '{-11, -7, -13, -9}; tbl[1].i_lin = 1;
    tbl[2].b = '{0, 0, 0, 0};
    tbl[2].e_def = '{0, 3, 0, 1};     tbl[2].i_def = 1;
    tbl[2].e_k2  = '{0, 6, 0, 2};     tbl[2].i_k2  = 1;
    tbl[2].e_lin = '{-1, 3, -3, 1};   tbl[2].i_lin = 1;

    rst_n = 1'b0;
    en    = 1'b1;
    start = 1'b0;
    Scurr_v = '0;
    W_v     = '0;
    b_v     = '0;
    step();
    step();
    check("rst_busy", longint'(busy_d), 0);
    check("rst_done", longint'(done_d), 0);
    check("rst_snext", longint'(sn_d != '0), 0);
    check("rst_max_val", longint'(mv_d), 0);
    check("rst_result", longint'(rs_d), 0);
    rst_n = 1'b1;
    step();

    // Table-driven directed vectors.
    for (int t = 0; t < 3; t++) begin
      load_tbl(t);
      apply();
      start = 1'b1;
      run_op($sformatf("tbl%0d", t));
      step();
      check($sformatf("tbl%0d_done_pulse", t), longint'(done_d), 0);
    end

    // Start retriggered during ACC is ignored; en low 5 cycles in ARG.
    load_tbl(0);
    apply();
    start = 1'b1;
    step();                 // edge 1
    start = 1'b0;
    step();                 // edge 2
    start = 1'b1;
    step();                 // edge 3
    start = 1'b0;
    step();
    step();
    step();                 // edge 6, in ARG
    en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    en = 1'b1;
    wait_done(60, n);
    check("freeze_latency", longint'(11 + n), longint'(LAT + 5));
    compare_all("freeze");
    en = 1'b0;
    step();
    step();
    check("freeze_done_hold", longint'(done_d), 1);
    en = 1'b1;
    step();
    check("freeze_done_drop", longint'(done_d), 0);
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (busy_d || done_d) cnt++;
    end
    check("no_second_op", longint'(cnt), 0);

    // Reset during ACC aborts with everything cleared.
    load_tbl(0);
    apply();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("abort_busy", longint'(busy_d), 0);
    check("abort_done", longint'(done_d), 0);
    check("abort_snext", longint'(sn_d != '0), 0);
    check("abort_max_val", longint'(mv_d), 0);
    check("abort_max_idx", longint'(mi_d), 0);
    check("abort_result", longint'(rs_d), 0);
    step();
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (busy_d || done_d) cnt++;
    end
    check("abort_no_done", longint'(cnt), 0);
    load_tbl(0);
    apply();
    start = 1'b1;
    run_op("after_abort");
    step();

    // Back-to-back: second start in the done cycle with b = 0.
    load_tbl(0);
    apply();
    start = 1'b1;
    run_op("b2b_first");
    load_tbl(2);
    apply();
    start = 1'b1;
    run_op("b2b_second");
    step();
    check("b2b_done_pulse", longint'(done_d), 0);

    // Randomized operations against the reference model.
    for (int r = 0; r < 20; r++) begin
      for (int j = 0; j < N; j++) cur_s[j] = rnd_val();
      for (int i = 0; i < M; i++) begin
        cur_b[i] = rnd_val();
        for (int j = 0; j < N; j++) cur_w[i][j] = rnd_val();
      end
      model();
      apply();
      start = 1'b1;
      run_op($sformatf("rnd%0d", r));
      e = $urandom_range(0, 3);
      repeat (e + 1) step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
